// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS control tokens, symbol-kind and alignment-state types
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

    typedef enum logic {
        SYM_CTRL,
        SYM_DATA
    } sym_kind_e;

    typedef enum logic {
        SEARCH,
        LOCKED
    } align_state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// rtl/tmds_symbol_decode.sv - combinational decode of one aligned 10-bit TMDS symbol
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] q,
    output logic       is_ctrl,
    output logic [1:0] c,
    output logic [7:0] d
);

    sym_kind_e  kind;
    logic [7:0] t;

    always_comb begin
        kind = SYM_CTRL;
        c    = 2'b00;
        case (q)
            CTRL_TOKEN_00: c = 2'b00;
            CTRL_TOKEN_01: c = 2'b01;
            CTRL_TOKEN_10: c = 2'b10;
            CTRL_TOKEN_11: c = 2'b11;
            default:       kind = SYM_DATA;
        endcase
    end

    // q[9] undoes DC-balance inversion, q[8] selects XOR vs XNOR chaining
    always_comb begin
        t    = q[9] ? ~q[7:0] : q[7:0];
        d    = 8'h00;
        d[0] = t[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        end
    end

    assign is_ctrl = (kind == SYM_CTRL);

endmodule

// File: rtl/tmds_symbol_decoder.sv
// rtl/tmds_symbol_decoder.sv - TMDS word aligner (control-token hunt) and symbol decoder
module tmds_symbol_decoder
    import tmds_pkg::*;
#(
    parameter int SEARCH_WINDOW = 1024,
    parameter int LOCK_COUNT    = 16,
    parameter int LOSS_WINDOW   = 2048
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] raw_in,
    output logic [7:0] data,
    output logic [1:0] c,
    output logic       de,
    output logic       locked,
    output logic [3:0] slip_offset,
    output logic       lock_lost
);

    localparam int RUN_W  = $clog2(LOCK_COUNT) + 1;
    localparam int WIN_W  = $clog2(SEARCH_WINDOW);
    localparam int LOSS_W = $clog2(LOSS_WINDOW);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WINDOW - 1);

    align_state_e      state_q;
    logic [9:0]        raw_prev_q;
    logic [9:0]        aligned_q;
    logic [9:0]        aligned_d;
    logic [19:0]       word_pair;
    logic [RUN_W-1:0]  run_q;
    logic [WIN_W-1:0]  win_q;
    logic [LOSS_W-1:0] loss_q;
    logic              skip_q;
    logic [3:0]        slip_q;
    logic [7:0]        data_q;
    logic [1:0]        c_q;
    logic              de_q;
    logic              locked_q;
    logic              lost_q;
    logic              sym_ctrl;
    logic [1:0]        sym_c;
    logic [7:0]        sym_d;

    // raw_prev holds the earlier bits, so offset k picks stream bits k..k+9
    assign word_pair = {raw_in, raw_prev_q};
    assign aligned_d = 10'(word_pair >> slip_q);

    tmds_symbol_decode u_decode (
        .q       (aligned_q),
        .is_ctrl (sym_ctrl),
        .c       (sym_c),
        .d       (sym_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEARCH;
            raw_prev_q <= '0;
            aligned_q  <= '0;
            run_q      <= '0;
            win_q      <= '0;
            loss_q     <= '0;
            skip_q     <= 1'b0;
            slip_q     <= '0;
            data_q     <= '0;
            c_q        <= '0;
            de_q       <= 1'b0;
            locked_q   <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            raw_prev_q <= raw_in;
            aligned_q  <= aligned_d;
            lost_q     <= 1'b0;
            case (state_q)
                SEARCH: begin
                    skip_q   <= 1'b0;
                    data_q   <= '0;
                    c_q      <= '0;
                    de_q     <= 1'b0;
                    locked_q <= 1'b0;
                    if (!skip_q && sym_ctrl && run_q == RUN_LAST) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                        c_q      <= sym_c;
                        run_q    <= '0;
                        win_q    <= '0;
                        loss_q   <= '0;
                    end else if (win_q == WIN_LAST) begin
                        // the word already in aligned_q was cut at the old offset
                        slip_q <= (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
                        run_q  <= '0;
                        win_q  <= '0;
                        skip_q <= 1'b1;
                    end else begin
                        win_q <= win_q + WIN_W'(1);
                        if (!skip_q) begin
                            run_q <= sym_ctrl ? run_q + RUN_W'(1) : '0;
                        end
                    end
                end
                LOCKED: begin
                    if (sym_ctrl) begin
                        loss_q <= '0;
                        de_q   <= 1'b0;
                        data_q <= '0;
                        c_q    <= sym_c;
                    end else if (loss_q == LOSS_LAST) begin
                        state_q  <= SEARCH;
                        lost_q   <= 1'b1;
                        locked_q <= 1'b0;
                        loss_q   <= '0;
                        run_q    <= '0;
                        win_q    <= '0;
                        de_q     <= 1'b0;
                        data_q   <= '0;
                        c_q      <= '0;
                    end else begin
                        loss_q <= loss_q + LOSS_W'(1);
                        de_q   <= 1'b1;
                        data_q <= sym_d;
                    end
                end
                default: state_q <= SEARCH;
            endcase
        end
    end

    assign data        = data_q;
    assign c           = c_q;
    assign de          = de_q;
    assign locked      = locked_q;
    assign slip_offset = slip_q;
    assign lock_lost   = lost_q;

endmodule

// File: tb/tb_tmds_symbol_decoder.sv
// tb/tb_tmds_symbol_decoder.sv - self-checking bench for tmds_symbol_decoder
module tb_tmds_symbol_decoder;

    localparam int SW = 1024;
    localparam int LC = 16;
    localparam int LW = 2048;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] raw_in = '0;
    logic [7:0] data;
    logic [1:0] c;
    logic       de;
    logic       locked;
    logic [3:0] slip_offset;
    logic       lock_lost;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    bit bq[$];

    typedef struct {
        logic [9:0] q;
        logic       de;
        logic [7:0] data;
        logic [1:0] c;
    } vec_t;
    vec_t vt[9];

    tmds_symbol_decoder #(
        .SEARCH_WINDOW (SW),
        .LOCK_COUNT    (LC),
        .LOSS_WINDOW   (LW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw_in      (raw_in),
        .data        (data),
        .c           (c),
        .de          (de),
        .locked      (locked),
        .slip_offset (slip_offset),
        .lock_lost   (lock_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void ref_decode(input logic [9:0] q, output bit ctl,
                                       output logic [1:0] cv, output logic [7:0] dv);
        logic [7:0] t;
        ctl = 1'b1;
        case (q)
            10'h354: cv = 2'd0;
            10'h0AB: cv = 2'd1;
            10'h154: cv = 2'd2;
            10'h2AB: cv = 2'd3;
            default: begin ctl = 1'b0; cv = 2'd0; end
        endcase
        t  = q[9] ? ~q[7:0] : q[7:0];
        dv = 8'h00;
        dv[0] = t[0];
        for (int i = 1; i < 8; i++) dv[i] = (t[i] ^ t[i-1]) ^ ~q[8];
    endfunction

    // Behavioural model: bit offset into the serial stream plus run/window/loss tallies
    logic [9:0] m_prev, m_al, m_nal;
    int         m_off, m_run, m_win, m_loss;
    bit         m_lock, m_skip, m_sk, m_ctl;
    logic [1:0] m_cv;
    logic [7:0] m_dv;
    logic [7:0] e_data;
    logic [1:0] e_c;
    logic       e_de, e_locked, e_lost;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev = '0; m_al = '0; m_off = 0; m_run = 0; m_win = 0; m_loss = 0;
            m_lock = 0; m_skip = 0;
            e_data = '0; e_c = '0; e_de = 0; e_locked = 0; e_lost = 0;
        end else begin
            m_nal = 10'({raw_in, m_prev} >> m_off);
            ref_decode(m_al, m_ctl, m_cv, m_dv);
            m_sk   = m_skip;
            m_skip = 0;
            e_lost = 0;
            if (!m_lock) begin
                e_data = '0; e_c = '0; e_de = 0; e_locked = 0;
                m_win++;
                if (!m_sk) m_run = m_ctl ? m_run + 1 : 0;
                if (m_run == LC) begin
                    m_lock = 1; e_locked = 1; e_c = m_cv; m_loss = 0;
                end else if (m_win == SW) begin
                    m_off = (m_off + 1) % 10; m_win = 0; m_run = 0; m_skip = 1;
                end
            end else if (m_ctl) begin
                m_loss = 0; e_de = 0; e_data = '0; e_c = m_cv;
            end else begin
                m_loss++;
                if (m_loss == LW) begin
                    m_lock = 0; e_lost = 1; e_locked = 0; e_de = 0; e_data = '0; e_c = '0;
                    m_loss = 0; m_run = 0; m_win = 0;
                end else begin
                    e_de = 1; e_data = m_dv;
                end
            end
            m_al   = m_nal;
            m_prev = raw_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            checks++;
            if ({data, c, de, locked, slip_offset, lock_lost} !==
                {e_data, e_c, e_de, e_locked, 4'(m_off), e_lost}) begin
                errors++;
                $display("FAIL model t=%0t got data=%h c=%0d de=%b locked=%b off=%0d lost=%b expected data=%h c=%0d de=%b locked=%b off=%0d lost=%b",
                         $time, data, c, de, locked, slip_offset, lock_lost,
                         e_data, e_c, e_de, e_locked, m_off, e_lost);
            end
        end
    end

    task automatic push_sym(input logic [9:0] s);
        for (int j = 0; j < 10; j++) bq.push_back(s[j]);
    endtask

    task automatic push_fill(input int n, input bit rnd);
        for (int j = 0; j < n; j++) bq.push_back(rnd ? bit'($urandom_range(0, 1)) : 1'b0);
    endtask

    task automatic tick();
        logic [9:0] w;
        @(negedge clk);
        if (bq.size() >= 10) begin
            for (int j = 0; j < 10; j++) w[j] = bq.pop_front();
            raw_in = w;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        raw_in = '0;
        bq.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int nlock, first, slips, pulses, seen, cyc, r, n;
        logic [3:0] prev;
        logic [9:0] toks[4];
        toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;

        vt[0] = '{10'h100, 1'b1, 8'h00, 2'b00};
        vt[1] = '{10'h2FF, 1'b1, 8'hFE, 2'b00};
        vt[2] = '{10'h2AB, 1'b0, 8'h00, 2'b11};
        vt[3] = '{10'h1FF, 1'b1, 8'h01, 2'b11};
        vt[4] = '{10'h3F0, 1'b1, 8'h11, 2'b11};
        vt[5] = '{10'h0AB, 1'b0, 8'h00, 2'b01};
        vt[6] = '{10'h055, 1'b1, 8'h01, 2'b01};
        vt[7] = '{10'h154, 1'b0, 8'h00, 2'b10};
        vt[8] = '{10'h354, 1'b0, 8'h00, 2'b00};

        repeat (4) begin @(negedge clk); raw_in = 10'($urandom); end
        @(negedge clk);
        chk("rst_data", data, 0);
        chk("rst_c", c, 0);
        chk("rst_de", de, 0);
        chk("rst_locked", locked, 0);
        chk("rst_slip", slip_offset, 0);
        chk("rst_lost", lock_lost, 0);
        chk_en = 1'b1;

        rst_n = 1'b1; raw_in = 10'h100; nlock = 0;
        for (int k = 1; k <= 10 * SW; k++) begin
            @(negedge clk);
            if (locked !== 1'b0) nlock++;
            if (k % SW == 0 || k % SW == SW - 1) chk("search_slip", slip_offset, (k / SW) % 10);
        end
        chk("search_never_locked", nlock, 0);

        do_reset();
        rst_n = 1'b1; raw_in = 10'h354; first = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (locked === 1'b1 && first == 0) first = k;
        end
        chk("lock_cycle", first, 18);
        chk("lock_slip", slip_offset, 0);
        chk("lock_c", c, 0);
        chk("lock_de", de, 0);

        for (int i = 0; i < 11; i++) begin
            raw_in = (i < 9) ? vt[i].q : 10'h354;
            @(negedge clk);
            if (i >= 2) begin
                chk($sformatf("vec%0d_de", i - 2), de, vt[i-2].de);
                chk($sformatf("vec%0d_data", i - 2), data, vt[i-2].data);
                chk($sformatf("vec%0d_c", i - 2), c, vt[i-2].c);
            end
        end

        do_reset();
        push_fill(3, 1'b0);
        repeat (3300) push_sym(10'h0AB);
        rst_n = 1'b1; slips = 0; prev = slip_offset; n = 0;
        while (n < 5000 && locked !== 1'b1) begin
            tick(); n++;
            if (slip_offset !== prev) slips++;
            prev = slip_offset;
        end
        chk("offs_locked", locked, 1);
        chk("offs_slips", slips, 3);
        chk("offs_slip", slip_offset, 3);
        repeat (3) tick();
        chk("offs_c", c, 1);
        chk("offs_de", de, 0);

        bq.delete();
        push_fill(3, 1'b0);
        repeat (2200) push_sym(10'h100);
        pulses = 0;
        repeat (2150) begin
            tick();
            if (lock_lost === 1'b1) pulses++;
        end
        chk("loss_pulses", pulses, 1);
        chk("loss_locked", locked, 0);
        chk("loss_slip", slip_offset, 3);

        bq.delete();
        push_fill(3, 1'b0);
        repeat (200) push_sym(10'h0AB);
        n = 0;
        while (n < 150 && locked !== 1'b1) begin tick(); n++; end
        chk("relock_locked", locked, 1);
        chk("relock_slip", slip_offset, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_locked", locked, 0);
        chk("async_slip", slip_offset, 0);
        chk("async_c", c, 0);
        chk("async_de", de, 0);
        bq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1; raw_in = 10'h354; first = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (locked === 1'b1 && first == 0) first = k;
        end
        chk("async_relock_cycle", first, 18);
        chk("async_relock_slip", slip_offset, 0);

        do_reset();
        push_fill($urandom_range(0, 9), 1'b1);
        rst_n = 1'b1; cyc = 0; seen = 0;
        while (cyc < 14000) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
                first = $urandom_range(0, 3);
                repeat ($urandom_range(8, 40)) push_sym(toks[first]);
            end else if (r < 98) begin
                repeat ($urandom_range(1, 80)) push_sym(10'($urandom));
            end else begin
                repeat (LW + 50) push_sym(10'h100);
            end
            while (bq.size() >= 10) begin
                tick(); cyc++;
                if (locked === 1'b1) seen++;
            end
        end
        chk("rand_locked_seen", seen > 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
